// File: rtl/rv32i_exec_core.sv
// rv32i_exec_core: RV32I register file, ALU with ZCNV flags and sized-store data memory
module rv32i_exec_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fu_a,
  input  logic [31:0] fu_b,
  input  logic [3:0]  fu_fs,
  output logic [31:0] fu_s,
  output logic [3:0]  fu_zcnv,
  input  logic [4:0]  rf_rd_addr0,
  output logic [31:0] rf_rd_dout0,
  input  logic [4:0]  rf_rd_addr1,
  output logic [31:0] rf_rd_dout1,
  input  logic [4:0]  rf_wr_addr0,
  input  logic [31:0] rf_wr_din0,
  input  logic        rf_we0,
  input  logic [6:0]  dm_rd_addr0,
  output logic [31:0] dm_rd_dout0,
  input  logic [6:0]  dm_wr_addr0,
  input  logic [31:0] dm_wr_din0,
  input  logic        dm_we0,
  input  logic [2:0]  dm_wr_strb
);
  logic [31:0] rf [32];
  logic [31:0] mem [128];
  logic [32:0] sum, dif;
  logic        c, v;
  assign sum = {1'b0, fu_a} + {1'b0, fu_b};
  assign dif = {1'b0, fu_a} - {1'b0, fu_b};
  // function unit result select
  always_comb begin
    case (fu_fs)
      4'd0:    fu_s = sum[31:0];
      4'd1:    fu_s = dif[31:0];
      4'd2:    fu_s = fu_a << fu_b[4:0];
      4'd3:    fu_s = {31'b0, $signed(fu_a) < $signed(fu_b)};
      4'd4:    fu_s = {31'b0, fu_a < fu_b};
      4'd5:    fu_s = fu_a ^ fu_b;
      4'd6:    fu_s = fu_a >> fu_b[4:0];
      4'd7:    fu_s = $signed(fu_a) >>> fu_b[4:0];
      4'd8:    fu_s = fu_a | fu_b;
      4'd9:    fu_s = fu_a & fu_b;
      4'd10:   fu_s = fu_b;
      4'd11:   fu_s = fu_a;
      default: fu_s = '0;
    endcase
  end
  assign c = fu_fs == 4'd0 ? sum[32] : fu_fs == 4'd1 ? ~dif[32] : 1'b0;
  assign v = fu_fs == 4'd0 ? (fu_a[31] == fu_b[31]) && (sum[31] != fu_a[31]) :
             fu_fs == 4'd1 ? (fu_a[31] != fu_b[31]) && (dif[31] != fu_a[31]) : 1'b0;
  assign fu_zcnv = {fu_s == '0, c, fu_s[31], v};
  assign rf_rd_dout0 = rf_rd_addr0 == '0 ? '0 : rf[rf_rd_addr0];
  assign rf_rd_dout1 = rf_rd_addr1 == '0 ? '0 : rf[rf_rd_addr1];
  assign dm_rd_dout0 = mem[dm_rd_addr0];
  // register file: async clear, x0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we0 && rf_wr_addr0 != '0) begin
      rf[rf_wr_addr0] <= rf_wr_din0;
    end
  end
  // data memory: async clear, byte/half/word stores merge into the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (dm_we0 && dm_wr_strb <= 3'd2) begin
      mem[dm_wr_addr0] <= dm_wr_strb == 3'd0 ? {mem[dm_wr_addr0][31:8], dm_wr_din0[7:0]} :
                          dm_wr_strb == 3'd1 ? {mem[dm_wr_addr0][31:16], dm_wr_din0[15:0]} :
                          dm_wr_din0;
    end
  end
endmodule

// File: tb/tb_rv32i_exec_core.sv
// tb_rv32i_exec_core: directed and randomized checks against a behavioural model
module tb_rv32i_exec_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fu_a, fu_b, fu_s;
  logic [3:0]  fu_fs, fu_zcnv;
  logic [4:0]  rf_rd_addr0, rf_rd_addr1, rf_wr_addr0;
  logic [31:0] rf_rd_dout0, rf_rd_dout1, rf_wr_din0;
  logic        rf_we0;
  logic [6:0]  dm_rd_addr0, dm_wr_addr0;
  logic [31:0] dm_rd_dout0, dm_wr_din0;
  logic        dm_we0;
  logic [2:0]  dm_wr_strb;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] rf_m [32];
  logic [31:0] mem_m [128];

  rv32i_exec_core dut (
    .clk(clk), .rst(rst),
    .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_s(fu_s), .fu_zcnv(fu_zcnv),
    .rf_rd_addr0(rf_rd_addr0), .rf_rd_dout0(rf_rd_dout0),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_dout1(rf_rd_dout1),
    .rf_wr_addr0(rf_wr_addr0), .rf_wr_din0(rf_wr_din0), .rf_we0(rf_we0),
    .dm_rd_addr0(dm_rd_addr0), .dm_rd_dout0(dm_rd_dout0),
    .dm_wr_addr0(dm_wr_addr0), .dm_wr_din0(dm_wr_din0), .dm_we0(dm_we0),
    .dm_wr_strb(dm_wr_strb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void fu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fs,
                                   output logic [31:0] s, output logic [3:0] f);
    longint unsigned us;
    longint ss;
    logic cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (fs)
      4'd0: begin
        us = longint'(a) + longint'(b);
        ss = longint'($signed(a)) + longint'($signed(b));
        s = us[31:0];
        cf = us >= 64'h1_0000_0000;
        vf = ss > 64'sd2147483647 || ss < -64'sd2147483648;
      end
      4'd1: begin
        ss = longint'($signed(a)) - longint'($signed(b));
        s = a - b;
        cf = a >= b;
        vf = ss > 64'sd2147483647 || ss < -64'sd2147483648;
      end
      4'd2: s = a << b[4:0];
      4'd3: s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: s = (a < b) ? 32'd1 : 32'd0;
      4'd5: s = a ^ b;
      4'd6: s = a >> b[4:0];
      4'd7: s = $signed(a) >>> b[4:0];
      4'd8: s = a | b;
      4'd9: s = a & b;
      4'd10: s = b;
      4'd11: s = a;
      default: s = 32'd0;
    endcase
    f = {s == 32'd0, cf, s[31], vf};
  endfunction

  task automatic alu(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] fs, input logic [31:0] es, input logic [3:0] ef);
    fu_a = a; fu_b = b; fu_fs = fs;
    #1;
    chk({tag, "_s"}, fu_s, es);
    chk({tag, "_zcnv"}, {28'd0, fu_zcnv}, {28'd0, ef});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] es;
    logic [3:0]  ef;
    rst = 1'b1;
    fu_a = '0; fu_b = '0; fu_fs = '0;
    rf_rd_addr0 = 5'd1; rf_rd_addr1 = 5'd31;
    rf_wr_addr0 = '0; rf_wr_din0 = '0; rf_we0 = 1'b0;
    dm_rd_addr0 = 7'd0; dm_wr_addr0 = '0; dm_wr_din0 = '0; dm_we0 = 1'b0; dm_wr_strb = 3'd2;
    #2;
    chk("rst_x1", rf_rd_dout0, 32'd0);
    chk("rst_x31", rf_rd_dout1, 32'd0);
    chk("rst_m0", dm_rd_dout0, 32'd0);
    dm_rd_addr0 = 7'd127;
    #1 chk("rst_m127", dm_rd_dout0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    rf_we0 = 1'b1; rf_wr_addr0 = 5'd0; rf_wr_din0 = 32'hDEAD_BEEF;
    tick();
    rf_wr_addr0 = 5'd5; rf_wr_din0 = 32'h1234_5678;
    rf_rd_addr0 = 5'd5; rf_rd_addr1 = 5'd5;
    #1;
    chk("x5_pre0", rf_rd_dout0, 32'd0);
    chk("x5_pre1", rf_rd_dout1, 32'd0);
    tick();
    rf_we0 = 1'b0;
    chk("x5_post0", rf_rd_dout0, 32'h1234_5678);
    chk("x5_post1", rf_rd_dout1, 32'h1234_5678);
    rf_rd_addr0 = 5'd0;
    #1 chk("x0_zero", rf_rd_dout0, 32'd0);

    alu("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 4'b1100);
    alu("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 4'b0011);
    alu("sub_eq", 32'd5, 32'd5, 4'd1, 32'd0, 4'b1100);
    alu("sra", 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 4'b0010);
    alu("srl", 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 4'b0000);
    alu("slt", 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 4'b0000);
    alu("sltu", 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 4'b1000);
    alu("zero_op", 32'h1234, 32'h5678, 4'd13, 32'd0, 4'b1000);

    dm_we0 = 1'b1; dm_wr_addr0 = 7'd3; dm_rd_addr0 = 7'd3;
    dm_wr_strb = 3'd2; dm_wr_din0 = 32'h1122_3344;
    tick();
    chk("sw", dm_rd_dout0, 32'h1122_3344);
    dm_wr_din0 = 32'hAABB_CCDD; dm_wr_strb = 3'd0;
    #1 chk("sb_pre", dm_rd_dout0, 32'h1122_3344);
    tick();
    chk("sb", dm_rd_dout0, 32'h1122_33DD);
    dm_wr_strb = 3'd1;
    tick();
    chk("sh", dm_rd_dout0, 32'h1122_CCDD);
    dm_wr_strb = 3'd3; dm_wr_din0 = 32'h5555_5555;
    tick();
    chk("strb3", dm_rd_dout0, 32'h1122_CCDD);
    dm_we0 = 1'b0;

    rf_we0 = 1'b1; rf_wr_addr0 = 5'd7; rf_wr_din0 = 32'hCAFE_F00D;
    dm_we0 = 1'b1; dm_wr_addr0 = 7'd10; dm_wr_strb = 3'd2; dm_wr_din0 = 32'h0BAD_F00D;
    rf_rd_addr0 = 5'd7; dm_rd_addr0 = 7'd10;
    tick();
    chk("x7_wr", rf_rd_dout0, 32'hCAFE_F00D);
    chk("m10_wr", dm_rd_dout0, 32'h0BAD_F00D);
    rst = 1'b1;
    #1;
    chk("x7_async", rf_rd_dout0, 32'd0);
    chk("m10_async", dm_rd_dout0, 32'd0);
    tick();
    chk("x7_rst_prio", rf_rd_dout0, 32'd0);
    chk("m10_rst_prio", dm_rd_dout0, 32'd0);
    rf_we0 = 1'b0; dm_we0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    for (int i = 0; i < 128; i++) mem_m[i] = '0;
    for (int it = 0; it < 300; it++) begin
      fu_a = pick(); fu_b = pick(); fu_fs = 4'($urandom_range(0, 15));
      rf_rd_addr0 = 5'($urandom_range(0, 31)); rf_rd_addr1 = 5'($urandom_range(0, 31));
      rf_we0 = 1'($urandom); rf_wr_addr0 = 5'($urandom_range(0, 7)); rf_wr_din0 = $urandom;
      dm_rd_addr0 = 7'($urandom_range(0, 7)); dm_wr_addr0 = 7'($urandom_range(0, 7));
      if (it % 50 == 0) begin
        dm_rd_addr0 = 7'($urandom_range(120, 127));
        dm_wr_addr0 = dm_rd_addr0;
      end
      dm_we0 = 1'($urandom); dm_wr_din0 = $urandom; dm_wr_strb = 3'($urandom_range(0, 7));
      #1;
      fu_model(fu_a, fu_b, fu_fs, es, ef);
      chk("r_fu_s", fu_s, es);
      chk("r_fu_zcnv", {28'd0, fu_zcnv}, {28'd0, ef});
      chk("r_rd0", rf_rd_dout0, rf_m[rf_rd_addr0]);
      chk("r_rd1", rf_rd_dout1, rf_m[rf_rd_addr1]);
      chk("r_dm", dm_rd_dout0, mem_m[dm_rd_addr0]);
      tick();
      if (rf_we0 && rf_wr_addr0 != 5'd0) rf_m[rf_wr_addr0] = rf_wr_din0;
      if (dm_we0 && dm_wr_strb == 3'd0) mem_m[dm_wr_addr0][7:0] = dm_wr_din0[7:0];
      if (dm_we0 && dm_wr_strb == 3'd1) mem_m[dm_wr_addr0][15:0] = dm_wr_din0[15:0];
      if (dm_we0 && dm_wr_strb == 3'd2) mem_m[dm_wr_addr0] = dm_wr_din0;
      chk("r_dm_post", dm_rd_dout0, mem_m[dm_rd_addr0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
